// File: rtl/alu_result_queue.sv
// Result FIFO between the ALU and the TX/sync consumer: first-word fall-through, drop-on-full.
// Optional saturating drop counter enabled by defining ALU_RESULT_QUEUE_DROP_CNT_EN.
module alu_result_queue #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic [CNT_WIDTH-1:0]  COUNT,
  output logic                  OVERFLOW,
  input  logic                  CLR_OVF,
  output logic [7:0]            DROP_CNT
);

  localparam int unsigned AW = CNT_WIDTH - 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_WIDTH-1:0]  r_wptr;
  logic [CNT_WIDTH-1:0]  r_rptr;
  logic                  r_ovf;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Pointers carry one extra MSB so full and empty are distinguishable at equal indices.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_pop  = !w_empty && TX_READY;
  assign w_push = IN_VALID && (!w_full || w_pop);
  assign w_drop = IN_VALID && w_full && !w_pop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + CNT_WIDTH'(1);
      if (w_pop)  r_rptr <= r_rptr + CNT_WIDTH'(1);
    end
  end

  // Storage is intentionally not reset; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= IN_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (CLR_OVF) r_ovf <= 1'b0;
  end

`ifdef ALU_RESULT_QUEUE_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_drop_cnt <= '0;
    end else if (CLR_OVF) begin
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign DROP_CNT = r_drop_cnt;
`else
  assign DROP_CNT = '0;
`endif

  assign TX_DATA  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign TX_VALID = !w_empty;
  assign FULL     = w_full;
  assign EMPTY    = w_empty;
  assign COUNT    = r_wptr - r_rptr;
  assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_alu_result_queue.sv
// Directed self-checking bench for alu_result_queue (checks DROP_CNT against the macro setting).
module tb_alu_result_queue;

  logic       CLK;
  logic       RST;
  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;
  logic       FULL;
  logic       EMPTY;
  logic [2:0] COUNT;
  logic       OVERFLOW;
  logic       CLR_OVF;
  logic [7:0] DROP_CNT;

  int vectors    = 0;
  int miscompares = 0;

`ifdef ALU_RESULT_QUEUE_DROP_CNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  alu_result_queue #(
    .DATA_WIDTH(8),
    .DEPTH     (4),
    .CNT_WIDTH (3)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IN_DATA (IN_DATA),
    .IN_VALID(IN_VALID),
    .TX_DATA (TX_DATA),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .FULL    (FULL),
    .EMPTY   (EMPTY),
    .COUNT   (COUNT),
    .OVERFLOW(OVERFLOW),
    .CLR_OVF (CLR_OVF),
    .DROP_CNT(DROP_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    IN_DATA  = d;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
  endtask

  task automatic status(input string tag, input logic [2:0] cnt, input logic full,
                        input logic empty, input logic ovf);
    chk({tag, "_count"}, 32'(COUNT), 32'(cnt));
    chk({tag, "_full"},  32'(FULL),  32'(full));
    chk({tag, "_empty"}, 32'(EMPTY), 32'(empty));
    chk({tag, "_valid"}, 32'(TX_VALID), 32'(!empty));
    chk({tag, "_ovf"},   32'(OVERFLOW), 32'(ovf));
  endtask

  initial begin
    RST      = 1'b1;
    IN_DATA  = 8'h00;
    IN_VALID = 1'b0;
    TX_READY = 1'b0;
    CLR_OVF  = 1'b0;
    #12;
    status("reset", 3'd0, 1'b0, 1'b1, 1'b0);
    chk("reset_txdata", 32'(TX_DATA), 32'h0);
    chk("reset_dropcnt", 32'(DROP_CNT), 32'h0);
    RST = 1'b0;
    step();

    // Single result, held under backpressure
    push(8'h5A);
    status("one", 3'd1, 1'b0, 1'b0, 1'b0);
    chk("one_data", 32'(TX_DATA), 32'h5A);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_data", 32'(TX_DATA), 32'h5A);
      chk("hold_valid", 32'(TX_VALID), 32'h1);
    end
    TX_READY = 1'b1;
    step();
    TX_READY = 1'b0;
    status("drain1", 3'd0, 1'b0, 1'b1, 1'b0);
    chk("drain1_data", 32'(TX_DATA), 32'h0);
    TX_READY = 1'b1;
    step();
    chk("ready_empty_count", 32'(COUNT), 32'h0);
    TX_READY = 1'b0;

    // Fill then drain in order
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    status("fill", 3'd4, 1'b1, 1'b0, 1'b0);
    TX_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", 32'(TX_DATA), 32'(i));
      step();
    end
    TX_READY = 1'b0;
    status("drained", 3'd0, 1'b0, 1'b1, 1'b0);

    // Drop on full
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    push(8'h77);
    status("drop", 3'd4, 1'b1, 1'b0, 1'b1);
    chk("drop_head", 32'(TX_DATA), 32'h21);
    chk("drop_dropcnt", 32'(DROP_CNT), DC_EN ? 32'h1 : 32'h0);

    // Full with simultaneous pop accepts the new result
    TX_READY = 1'b1;
    push(8'h99);
    TX_READY = 1'b0;
    status("fullpop", 3'd4, 1'b1, 1'b0, 1'b1);
    chk("fullpop_dropcnt", 32'(DROP_CNT), DC_EN ? 32'h1 : 32'h0);
    TX_READY = 1'b1;
    chk("fp_out1", 32'(TX_DATA), 32'h22); step();
    chk("fp_out2", 32'(TX_DATA), 32'h23); step();
    chk("fp_out3", 32'(TX_DATA), 32'h24); step();
    chk("fp_out4", 32'(TX_DATA), 32'h99); step();
    TX_READY = 1'b0;
    status("fp_done", 3'd0, 1'b0, 1'b1, 1'b1);

    // Clear, then drop coinciding with clear: set wins
    CLR_OVF = 1'b1;
    step();
    CLR_OVF = 1'b0;
    chk("clr_ovf", 32'(OVERFLOW), 32'h0);
    chk("clr_dropcnt", 32'(DROP_CNT), 32'h0);
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    push(8'h88); push(8'h89);
    chk("drop2_dropcnt", 32'(DROP_CNT), DC_EN ? 32'h2 : 32'h0);
    CLR_OVF = 1'b1;
    push(8'h8A);
    CLR_OVF = 1'b0;
    chk("clrdrop_ovf", 32'(OVERFLOW), 32'h1);
    chk("clrdrop_dropcnt", 32'(DROP_CNT), DC_EN ? 32'h1 : 32'h0);
    TX_READY = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("clrdrop_order", 32'(TX_DATA), 32'h30 + 32'(i));
      step();
    end
    TX_READY = 1'b0;
    CLR_OVF = 1'b1;
    step();
    CLR_OVF = 1'b0;
    status("cleared", 3'd0, 1'b0, 1'b1, 1'b0);

    // Continuous stream across pointer wrap
    TX_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      IN_DATA  = 8'h10 + 8'(i);
      IN_VALID = 1'b1;
      step();
      chk("stream_data", 32'(TX_DATA), 32'h10 + 32'(i));
      chk("stream_count", 32'(COUNT), 32'h1);
    end
    IN_VALID = 1'b0;
    step();
    TX_READY = 1'b0;
    status("stream_end", 3'd0, 1'b0, 1'b1, 1'b0);

    // Async reset with entries queued and overflow set
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    push(8'h45);
    TX_READY = 1'b1;
    step();
    TX_READY = 1'b0;
    status("prerst", 3'd3, 1'b0, 1'b0, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    status("asyncrst", 3'd0, 1'b0, 1'b1, 1'b0);
    chk("asyncrst_data", 32'(TX_DATA), 32'h0);
    chk("asyncrst_dropcnt", 32'(DROP_CNT), 32'h0);
    #1;
    RST = 1'b0;
    push(8'hAB);
    status("postrst", 3'd1, 1'b0, 1'b0, 1'b0);
    chk("postrst_data", 32'(TX_DATA), 32'hAB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
